// File: rtl/mrelbp_pkg.sv
// Shared constants, state encoding and bin addressing for the MRELBP joint histogram stage.
package mrelbp_pkg;

  localparam int CODE_W    = 4;
  localparam int CI_BINS   = 2;
  localparam int NI_BINS   = 10;
  localparam int RD_BINS   = 10;
  localparam int BANK_BINS = CI_BINS * NI_BINS * RD_BINS;
  localparam int ADDR_W    = 8;

  localparam logic [CODE_W-1:0] NI_LIMIT = CODE_W'(NI_BINS);
  localparam logic [CODE_W-1:0] RD_LIMIT = CODE_W'(RD_BINS);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, OUT, DONE} hist_state_t;

  // Joint bin address inside one scale bank: ci*100 + ni*10 + rd.
  function automatic logic [ADDR_W-1:0] bin_addr(input logic ci,
                                                 input logic [CODE_W-1:0] ni,
                                                 input logic [CODE_W-1:0] rd);
    logic [ADDR_W-1:0] a;
    a = (ci ? ADDR_W'(NI_BINS * RD_BINS) : '0)
      + ADDR_W'(ni) * ADDR_W'(RD_BINS)
      + ADDR_W'(rd);
    return a;
  endfunction

endpackage

// File: rtl/mrelbp_hist_bank.sv
// One scale's histogram RAM with a two-stage read-modify-write increment pipeline.
module mrelbp_hist_bank
  import mrelbp_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_valid,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              rd_sel,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data
);

  logic [CNT_W-1:0]  mem [BANK_BINS];
  logic [CNT_W-1:0]  rdata_q;
  logic              b_valid_q, b_valid_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic              fwd_q, fwd_d;
  logic [CNT_W-1:0]  fwd_val_q, fwd_val_d;
  logic [CNT_W-1:0]  b_base, b_inc;
  logic [ADDR_W-1:0] raddr, waddr;
  logic              we;
  logic [CNT_W-1:0]  wdata;

  always_comb begin
    // The RAM output is stale when the previous code wrote the same bin this cycle.
    b_base    = fwd_q ? fwd_val_q : rdata_q;
    b_inc     = (&b_base) ? b_base : b_base + CNT_W'(1);
    b_valid_d = acc_valid;
    b_addr_d  = acc_addr;
    fwd_d     = acc_valid && b_valid_q && (acc_addr == b_addr_q);
    fwd_val_d = b_inc;
    raddr     = rd_sel ? rd_addr : acc_addr;
    we        = clr_en || b_valid_q;
    waddr     = clr_en ? clr_addr : b_addr_q;
    wdata     = clr_en ? '0 : b_inc;
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid_q <= 1'b0;
      b_addr_q  <= '0;
      fwd_q     <= 1'b0;
      fwd_val_q <= '0;
    end else begin
      b_valid_q <= b_valid_d;
      b_addr_q  <= b_addr_d;
      fwd_q     <= fwd_d;
      fwd_val_q <= fwd_val_d;
    end
  end

  assign rd_data = rdata_q;

endmodule

// File: rtl/mrelbp_joint_hist.sv
// Joint CI x NI x RD histograms for three scales, cleared per frame and streamed out over AXI-Stream.
module mrelbp_joint_hist
  import mrelbp_pkg::*;
#(
  parameter int NUM_SCALES = 3,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       soft_rst,
  input  logic [15:0]                num_codes,
  input  logic                       code_valid,
  output logic                       code_ready,
  input  logic [NUM_SCALES-1:0]      ci,
  input  logic [4*NUM_SCALES-1:0]    ni,
  input  logic [4*NUM_SCALES-1:0]    rd,
  output logic [CNT_W-1:0]           m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       busy,
  output logic                       done,
  output logic                       err_code
);

  localparam int BANK_W = (NUM_SCALES > 1) ? $clog2(NUM_SCALES) : 1;

  hist_state_t state_q, state_d;
  logic [15:0]       num_q, num_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d, rd_addr_q, rd_addr_d;
  logic              drain_q, drain_d, err_q, err_d;
  logic [BANK_W-1:0] rd_bank_q, rd_bank_d, pend_bank_q, pend_bank_d;
  logic              issue_done_q, issue_done_d, pend_q, pend_d, pend_last_q, pend_last_d;
  logic [CNT_W-1:0]  fifo_data_q [2];
  logic [CNT_W-1:0]  fifo_data_d [2];
  logic [1:0]        fifo_last_q, fifo_last_d;
  logic              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]        fcnt_q, fcnt_d, fcnt_nx;

  logic                  flush, accept, clr_en, issue, pop, last_addr;
  logic [NUM_SCALES-1:0] in_range;
  logic [CNT_W-1:0]      bank_rdata [NUM_SCALES];
  logic [CNT_W-1:0]      rd_word;

  assign flush      = rst || soft_rst;
  assign code_ready = (state_q == ACCUM);
  assign accept     = code_valid && code_ready;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign err_code   = err_q;

  assign m_axis_tvalid = (fcnt_q != 2'd0);
  assign m_axis_tdata  = fifo_data_q[rptr_q];
  assign m_axis_tlast  = m_axis_tvalid && fifo_last_q[rptr_q];
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign rd_word       = bank_rdata[pend_bank_q];
  assign last_addr     = (rd_addr_q == ADDR_W'(BANK_BINS - 1));

  for (genvar s = 0; s < NUM_SCALES; s++) begin : g_bank
    logic [CODE_W-1:0] ni_s, rd_s;
    assign ni_s        = ni[4*s +: 4];
    assign rd_s        = rd[4*s +: 4];
    assign in_range[s] = (ni_s < NI_LIMIT) && (rd_s < RD_LIMIT);

    mrelbp_hist_bank #(.CNT_W(CNT_W)) u_bank (
      .clk       (clk),
      .rst       (flush),
      .acc_valid (accept && in_range[s]),
      .acc_addr  (bin_addr(ci[s], ni_s, rd_s)),
      .clr_en    (clr_en),
      .clr_addr  (clr_addr_q),
      .rd_sel    (state_q == OUT),
      .rd_addr   (rd_addr_q),
      .rd_data   (bank_rdata[s])
    );
  end

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    cnt_d        = cnt_q;
    clr_addr_d   = clr_addr_q;
    drain_d      = drain_q;
    err_d        = err_q;
    rd_addr_d    = rd_addr_q;
    rd_bank_d    = rd_bank_q;
    issue_done_d = issue_done_q;
    pend_d       = 1'b0;
    pend_bank_d  = pend_bank_q;
    pend_last_d  = pend_last_q;
    fifo_data_d  = fifo_data_q;
    fifo_last_d  = fifo_last_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    clr_en       = 1'b0;

    // A read is issued only if its data is guaranteed a skid slot next cycle.
    fcnt_nx = fcnt_q + {1'b0, pend_q} - {1'b0, pop};
    fcnt_d  = fcnt_nx;
    issue   = (state_q == OUT) && !issue_done_q && (fcnt_nx < 2'd2);
    if (pend_q) begin
      fifo_data_d[wptr_q] = rd_word;
      fifo_last_d[wptr_q] = pend_last_q;
      wptr_d              = ~wptr_q;
    end
    if (pop) rptr_d = ~rptr_q;

    unique case (state_q)
      IDLE: if (start) begin
        num_d      = num_codes;
        err_d      = 1'b0;
        clr_addr_d = '0;
        state_d    = CLEAR;
      end
      CLEAR: begin
        clr_en     = 1'b1;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == ADDR_W'(BANK_BINS - 1)) begin
          cnt_d   = '0;
          drain_d = 1'b0;
          state_d = (num_q == 16'd0) ? DRAIN : ACCUM;
        end
      end
      ACCUM: if (accept) begin
        cnt_d = cnt_q + 16'd1;
        if (!(&in_range)) err_d = 1'b1;
        if (cnt_q + 16'd1 == num_q) begin
          drain_d = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        drain_d      = 1'b1;
        rd_addr_d    = '0;
        rd_bank_d    = '0;
        issue_done_d = 1'b0;
        fcnt_d       = 2'd0;
        wptr_d       = 1'b0;
        rptr_d       = 1'b0;
        if (drain_q) state_d = OUT;
      end
      OUT: begin
        if (issue) begin
          pend_d      = 1'b1;
          pend_bank_d = rd_bank_q;
          pend_last_d = last_addr && (rd_bank_q == BANK_W'(NUM_SCALES - 1));
          rd_addr_d   = last_addr ? '0 : rd_addr_q + ADDR_W'(1);
          if (last_addr) begin
            rd_bank_d = rd_bank_q + BANK_W'(1);
            if (rd_bank_q == BANK_W'(NUM_SCALES - 1)) issue_done_d = 1'b1;
          end
        end
        if (pop && m_axis_tlast) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state_q      <= IDLE;
      num_q        <= '0;
      cnt_q        <= '0;
      clr_addr_q   <= '0;
      drain_q      <= 1'b0;
      err_q        <= 1'b0;
      rd_addr_q    <= '0;
      rd_bank_q    <= '0;
      issue_done_q <= 1'b0;
      pend_q       <= 1'b0;
      pend_bank_q  <= '0;
      pend_last_q  <= 1'b0;
      fifo_data_q  <= '{default: '0};
      fifo_last_q  <= '0;
      wptr_q       <= 1'b0;
      rptr_q       <= 1'b0;
      fcnt_q       <= 2'd0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      cnt_q        <= cnt_d;
      clr_addr_q   <= clr_addr_d;
      drain_q      <= drain_d;
      err_q        <= err_d;
      rd_addr_q    <= rd_addr_d;
      rd_bank_q    <= rd_bank_d;
      issue_done_q <= issue_done_d;
      pend_q       <= pend_d;
      pend_bank_q  <= pend_bank_d;
      pend_last_q  <= pend_last_d;
      fifo_data_q  <= fifo_data_d;
      fifo_last_q  <= fifo_last_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      fcnt_q       <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_mrelbp_joint_hist.sv
// Directed bench for mrelbp_joint_hist: frames of codes in, 600-word histograms checked bin-for-bin.
module tb_mrelbp_joint_hist;

  logic        clk, rst, start, soft_rst, code_valid, code_ready;
  logic [15:0] num_codes;
  logic [2:0]  ci;
  logic [11:0] ni, rd;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, busy, done, err_code;

  mrelbp_joint_hist dut (
    .clk(clk), .rst(rst), .start(start), .soft_rst(soft_rst), .num_codes(num_codes),
    .code_valid(code_valid), .code_ready(code_ready), .ci(ci), .ni(ni), .rd(rd),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done), .err_code(err_code)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  int          exp_hist [600];
  logic [31:0] got_hist [600];
  logic        err_exp;
  logic        ready_seen;
  int          tr_pat [6] = '{1, 0, 0, 1, 0, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
  endtask

  // Driver tasks (all called and returning at a negedge)
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; soft_rst = 1'b0; code_valid = 1'b0; num_codes = '0;
    ci = '0; ni = '0; rd = '0; m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_frame(input int num);
    for (int i = 0; i < 600; i++) exp_hist[i] = 0;
    err_exp = 1'b0;
    num_codes = 16'(num);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_clear_on_start", err_code, 0);
  endtask

  task automatic send_code(input logic [2:0] c, input logic [11:0] n, input logic [11:0] r);
    int t;
    code_valid = 1'b1; ci = c; ni = n; rd = r;
    t = 0;
    while (!code_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!code_ready) begin
      check("code_ready_timeout", 0, 1);
    end else begin
      for (int s = 0; s < 3; s++) begin
        int nv, rv;
        nv = int'(n[4*s +: 4]);
        rv = int'(r[4*s +: 4]);
        if (nv < 10 && rv < 10) exp_hist[s*200 + int'(c[s])*100 + nv*10 + rv]++;
        else err_exp = 1'b1;
      end
      @(negedge clk);
    end
    code_valid = 1'b0;
  endtask

  // mode 0: tready high, mode 1: fixed 1,0,0,1,0,1 pattern; abort_at < 0 means no abort
  task automatic collect(input int mode, input int abort_at);
    int          beat, cyc, first_cyc, last_cyc;
    logic        stalled, st_last;
    logic [31:0] st_data, exp;
    beat = 0; cyc = 0; first_cyc = 0; last_cyc = 0; stalled = 1'b0;
    st_data = '0; st_last = 1'b0; ready_seen = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 600; i++) exp_q.push_back(32'(exp_hist[i]));
    while (beat < 600 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (code_ready) ready_seen = 1'b1;
      if (stalled) begin
        check("stall_tvalid", m_axis_tvalid, 1);
        check("stall_tdata", m_axis_tdata, st_data);
        check("stall_tlast", m_axis_tlast, st_last);
      end
      m_axis_tready = (mode == 0) ? 1'b1 : (tr_pat[cyc % 6] != 0);
      if (m_axis_tvalid && m_axis_tready) begin
        exp = exp_q.pop_front();
        check($sformatf("tdata[%0d]", beat), m_axis_tdata, exp);
        check($sformatf("tlast[%0d]", beat), m_axis_tlast, (beat == 599) ? 1 : 0);
        got_hist[beat] = m_axis_tdata;
        if (beat == 0) first_cyc = cyc;
        last_cyc = cyc;
        if (beat == abort_at) begin
          soft_rst = 1'b1;
          @(negedge clk);
          soft_rst = 1'b0;
          m_axis_tready = 1'b0;
          check("abort_tvalid", m_axis_tvalid, 0);
          check("abort_busy", busy, 0);
          exp_q.delete();
          return;
        end
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = m_axis_tvalid;
        st_data = m_axis_tdata;
        st_last = m_axis_tlast;
      end
    end
    if (beat < 600) begin
      check("frame_timeout_beats", 32'(beat), 600);
    end else begin
      if (mode == 0) check("throughput_cycles", 32'(last_cyc - first_cyc), 599);
      check("done_low_on_last", done, 0);
      @(negedge clk);
      m_axis_tready = 1'b0;
      check("done_pulse", done, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
      check("err_code_end", err_code, err_exp);
    end
  endtask

  initial begin
    do_reset();
    check("rst_code_ready", code_ready, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_code, 0);

    // soft_rst wins over start in the same cycle
    start = 1'b1; soft_rst = 1'b1;
    @(negedge clk);
    start = 1'b0; soft_rst = 1'b0;
    check("softrst_priority_busy", busy, 0);
    @(negedge clk);
    check("softrst_priority_busy2", busy, 0);

    // Single code: bins 137, 337, 537
    start_frame(1);
    send_code(3'b111, 12'h333, 12'h777);
    collect(0, -1);
    check("single_bin137", got_hist[137], 1);
    check("single_bin337", got_hist[337], 1);
    check("single_bin537", got_hist[537], 1);
    check("single_bin136", got_hist[136], 0);

    // Five identical back-to-back codes
    start_frame(5);
    for (int i = 0; i < 5; i++) send_code(3'b000, 12'h222, 12'h444);
    collect(0, -1);
    check("hazard_bin24", got_hist[24], 5);
    check("hazard_bin424", got_hist[424], 5);

    // Alternating A,B,A,B
    start_frame(4);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) send_code(3'b000, 12'h222, 12'h444);
      else            send_code(3'b111, 12'h000, 12'h000);
    end
    collect(0, -1);
    check("abab_bin24", got_hist[24], 2);
    check("abab_bin100", got_hist[100], 2);
    check("abab_bin500", got_hist[500], 2);

    // 64 random in-range codes under backpressure
    start_frame(64);
    for (int i = 0; i < 64; i++) begin
      logic [11:0] n, r;
      for (int s = 0; s < 3; s++) begin
        n[4*s +: 4] = 4'($urandom_range(0, 9));
        r[4*s +: 4] = 4'($urandom_range(0, 9));
      end
      send_code(3'($urandom_range(0, 7)), n, r);
    end
    collect(1, -1);

    // Out-of-range NI on scale 1 only
    start_frame(1);
    send_code(3'b101, 12'h5C1, 12'h432);
    collect(0, -1);
    check("oor_err_code", err_code, 1);
    check("oor_bin112", got_hist[112], 1);
    check("oor_bin554", got_hist[554], 1);
    check("oor_bin312", got_hist[312], 0);

    // Abort mid-output, then a clean frame
    start_frame(1);
    send_code(3'b111, 12'h333, 12'h777);
    collect(0, 100);
    start_frame(1);
    send_code(3'b000, 12'h000, 12'h000);
    collect(0, -1);
    check("restart_bin0", got_hist[0], 1);
    check("restart_bin137_clean", got_hist[137], 0);

    // Zero-length frame
    start_frame(0);
    collect(0, -1);
    check("zero_no_code_ready", ready_seen, 0);
    check("zero_bin0", got_hist[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
